// File: rtl/uart_feeder_pkg.sv
// Shared FSM encodings and message ROM for the UART TX message feeder.
// No logic and no clocked state; constants only.
package uart_feeder_pkg;

  localparam int DEFAULT_MSG_LEN = 4;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ARM        = 3'd1;
  localparam logic [2:0] STROBE     = 3'd2;
  localparam logic [2:0] WAIT_START = 3'd3;
  localparam logic [2:0] WAIT_DONE  = 3'd4;

  localparam logic [7:0] MSG_BYTE0 = 8'h14;
  localparam logic [7:0] MSG_BYTE1 = 8'h35;
  localparam logic [7:0] MSG_BYTE2 = 8'hAA;
  localparam logic [7:0] MSG_BYTE3 = 8'h55;
  localparam logic [7:0] MSG_BYTE4 = 8'h0D;
  localparam logic [7:0] MSG_BYTE5 = 8'h0A;
  localparam logic [7:0] MSG_BYTE6 = 8'h00;
  localparam logic [7:0] MSG_BYTE7 = 8'h00;

  // Eight entries so any MSG_LEN in 1..8 indexes real content.
  function automatic logic [7:0] msg_rom(input logic [2:0] addr);
    logic [7:0] b;
    case (addr)
      3'd0:    b = MSG_BYTE0;
      3'd1:    b = MSG_BYTE1;
      3'd2:    b = MSG_BYTE2;
      3'd3:    b = MSG_BYTE3;
      3'd4:    b = MSG_BYTE4;
      3'd5:    b = MSG_BYTE5;
      3'd6:    b = MSG_BYTE6;
      default: b = MSG_BYTE7;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button -> 2-flop sync -> stability counter -> one-cycle press pulse on accepted rising level.
// Latency 2 sync + DEBOUNCE_CYC cycles after the raw edge; no backpressure, pulse is fire-and-forget.
module button_debouncer #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Counter only runs while the synced value disagrees with the accepted level, so any
  // bounce back to the old level restarts the stability window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_message_feeder.sv
// Sends a fixed MSG_LEN-byte ROM message into a UART TX core on each debounced button press.
// Tx_WR two cycles after trigger when TX idle; waits on Tx_BUSY, presses during a message are dropped.
module uart_tx_message_feeder
  import uart_feeder_pkg::*;
#(
  parameter int MSG_LEN       = DEFAULT_MSG_LEN,
  parameter int DEBOUNCE_CYC  = 16,
  parameter int START_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       Tx_BUSY,
  output logic [7:0] Tx_DATA,
  output logic       Tx_WR,
  output logic       sending,
  output logic       msg_done,
  output logic       tx_err
);

  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int TMR_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  logic             press;
  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic [2:0]       rom_addr;

  assign rom_addr = 3'(idx);

  button_debouncer #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .press (press)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      timer    <= '0;
      Tx_DATA  <= 8'h00;
      Tx_WR    <= 1'b0;
      sending  <= 1'b0;
      msg_done <= 1'b0;
      tx_err   <= 1'b0;
    end else begin
      Tx_WR    <= 1'b0;
      msg_done <= 1'b0;
      tx_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            state   <= ARM;
            sending <= 1'b1;
            idx     <= '0;
          end
        end
        ARM: begin
          if (!Tx_BUSY) begin
            state   <= STROBE;
            Tx_DATA <= msg_rom(rom_addr);
            Tx_WR   <= 1'b1;
          end
        end
        STROBE: begin
          state <= WAIT_START;
          timer <= '0;
        end
        WAIT_START: begin
          // A TX core that never acknowledges the write would otherwise hang the feeder.
          if (Tx_BUSY) begin
            state <= WAIT_DONE;
          end else if (timer == TMR_W'(START_TIMEOUT - 1)) begin
            state   <= IDLE;
            tx_err  <= 1'b1;
            sending <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!Tx_BUSY) begin
            if (idx == IDX_W'(MSG_LEN - 1)) begin
              state    <= IDLE;
              msg_done <= 1'b1;
              sending  <= 1'b0;
            end else begin
              idx   <= idx + 1'b1;
              state <= ARM;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_message_feeder.sv
// Directed bench for uart_tx_message_feeder with a simple UART TX busy model.
module tb_uart_tx_message_feeder;

  logic       clk;
  logic       reset;
  logic       button;
  logic       Tx_BUSY;
  logic [7:0] Tx_DATA;
  logic       Tx_WR;
  logic       sending;
  logic       msg_done;
  logic       tx_err;

  uart_tx_message_feeder dut (
    .clk     (clk),
    .reset   (reset),
    .button  (button),
    .Tx_BUSY (Tx_BUSY),
    .Tx_DATA (Tx_DATA),
    .Tx_WR   (Tx_WR),
    .sending (sending),
    .msg_done(msg_done),
    .tx_err  (tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // TX model: busy for 10 cycles starting the cycle after each Tx_WR.
  logic model_en   = 1'b1;
  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  int   busy_cnt   = 0;
  assign Tx_BUSY = model_busy | force_busy;

  always @(negedge clk) begin
    if (!model_en) begin
      busy_cnt   = 0;
      model_busy = 1'b0;
    end else begin
      if (busy_cnt > 0) begin
        model_busy = 1'b1;
        busy_cnt   = busy_cnt - 1;
      end else begin
        model_busy = 1'b0;
      end
      if (Tx_WR) busy_cnt = 10;
    end
  end

  // Event log sampled shortly after each rising edge; cyc labels the clock period.
  int         cyc = 0;
  int         wr_count, done_count, err_count, both_count, wr_while_busy;
  int         done_cyc, err_cyc;
  logic       sending_at_done;
  logic [7:0] wr_bytes [0:15];
  int         wr_cyc   [0:15];

  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    if (Tx_WR) begin
      if (wr_count < 16) begin
        wr_bytes[wr_count] = Tx_DATA;
        wr_cyc[wr_count]   = cyc;
      end
      wr_count = wr_count + 1;
      if (Tx_BUSY) wr_while_busy = wr_while_busy + 1;
    end
    if (msg_done) begin
      done_count      = done_count + 1;
      done_cyc        = cyc;
      sending_at_done = sending;
    end
    if (tx_err) begin
      err_count = err_count + 1;
      err_cyc   = cyc;
    end
    if (msg_done && tx_err) both_count = both_count + 1;
  end

  task automatic clear_log();
    wr_count        = 0;
    done_count      = 0;
    err_count       = 0;
    both_count      = 0;
    wr_while_busy   = 0;
    done_cyc        = 0;
    err_cyc         = 0;
    sending_at_done = 1'b1;
  endtask

  task automatic press_button(input int n);
    @(negedge clk);
    button = 1'b1;
    repeat (n) @(negedge clk);
    button = 1'b0;
  endtask

  task automatic wait_end(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done_count + err_count > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_wr(input int target, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (wr_count >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    button = 1'b0;
    clear_log();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    n_vec++; if (Tx_DATA !== 8'h00) begin n_miss++; $display("FAIL reset_tx_data got %h want 00", Tx_DATA); end
    n_vec++; if (Tx_WR !== 1'b0) begin n_miss++; $display("FAIL reset_tx_wr got %b want 0", Tx_WR); end
    n_vec++; if (sending !== 1'b0) begin n_miss++; $display("FAIL reset_sending got %b want 0", sending); end
    n_vec++; if (msg_done !== 1'b0) begin n_miss++; $display("FAIL reset_msg_done got %b want 0", msg_done); end
    n_vec++; if (tx_err !== 1'b0) begin n_miss++; $display("FAIL reset_tx_err got %b want 0", tx_err); end
    n_vec++; if (wr_count !== 0) begin n_miss++; $display("FAIL reset_no_strobe got %0d want 0", wr_count); end
  endtask

  task automatic test_message();
    logic [7:0] exp_b [0:3];
    bit ok;
    exp_b[0] = 8'h14; exp_b[1] = 8'h35; exp_b[2] = 8'hAA; exp_b[3] = 8'h55;
    clear_log();
    press_button(40);
    wait_end(300, ok);
    n_vec++; if (!ok) begin n_miss++; $display("FAIL msg_timeout got none want msg_done"); end
    repeat (30) @(negedge clk);
    n_vec++; if (wr_count !== 4) begin n_miss++; $display("FAIL msg_strobes got %0d want 4", wr_count); end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (wr_bytes[i] !== exp_b[i]) begin
        n_miss++; $display("FAIL msg_byte%0d got %h want %h", i, wr_bytes[i], exp_b[i]);
      end
    end
    // Tx_WR at s, busy seen s+2..s+11, ARM at s+12, next Tx_WR at s+13.
    for (int i = 1; i < 4; i++) begin
      n_vec++;
      if (wr_cyc[i] - wr_cyc[i-1] !== 13) begin
        n_miss++; $display("FAIL msg_gap%0d got %0d want 13", i, wr_cyc[i] - wr_cyc[i-1]);
      end
    end
    n_vec++; if (done_count !== 1) begin n_miss++; $display("FAIL msg_done_count got %0d want 1", done_count); end
    n_vec++; if (done_cyc - wr_cyc[3] !== 12) begin n_miss++; $display("FAIL msg_done_lat got %0d want 12", done_cyc - wr_cyc[3]); end
    n_vec++; if (sending_at_done !== 1'b0) begin n_miss++; $display("FAIL msg_sending_at_done got %b want 0", sending_at_done); end
    n_vec++; if (err_count !== 0) begin n_miss++; $display("FAIL msg_err_count got %0d want 0", err_count); end
    n_vec++; if (Tx_DATA !== 8'h55) begin n_miss++; $display("FAIL msg_data_hold got %h want 55", Tx_DATA); end
  endtask

  task automatic test_bounce();
    bit ok;
    clear_log();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      button = ~button;
      repeat (3) @(negedge clk);
    end
    press_button(40);
    wait_end(300, ok);
    repeat (40) @(negedge clk);
    n_vec++; if (wr_count !== 4) begin n_miss++; $display("FAIL bounce_strobes got %0d want 4", wr_count); end
    n_vec++; if (done_count !== 1) begin n_miss++; $display("FAIL bounce_done got %0d want 1", done_count); end
  endtask

  task automatic test_second_press();
    bit ok;
    clear_log();
    press_button(25);
    wait_wr(3, 200, ok);
    n_vec++; if (!ok || sending !== 1'b1) begin n_miss++; $display("FAIL press2_mid_msg got ok=%0b sending=%b want 1/1", ok, sending); end
    press_button(25);
    wait_end(200, ok);
    repeat (100) @(negedge clk);
    n_vec++; if (wr_count !== 4) begin n_miss++; $display("FAIL press2_strobes got %0d want 4", wr_count); end
    n_vec++; if (done_count !== 1) begin n_miss++; $display("FAIL press2_done got %0d want 1", done_count); end
    n_vec++; if (both_count !== 0) begin n_miss++; $display("FAIL press2_both got %0d want 0", both_count); end
  endtask

  task automatic test_busy_at_trigger();
    bit ok;
    int rel_cyc;
    clear_log();
    force_busy = 1'b1;
    press_button(25);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sending === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++; if (!ok) begin n_miss++; $display("FAIL busy_trigger got sending=0 want 1"); end
    repeat (20) @(negedge clk);
    n_vec++; if (wr_count !== 0) begin n_miss++; $display("FAIL busy_hold_strobes got %0d want 0", wr_count); end
    force_busy = 1'b0;
    rel_cyc    = cyc;
    wait_end(200, ok);
    repeat (20) @(negedge clk);
    // ARM is already waiting, so the write lands in the period after busy is seen low.
    n_vec++; if (wr_cyc[0] - rel_cyc !== 1) begin n_miss++; $display("FAIL busy_release_lat got %0d want 1", wr_cyc[0] - rel_cyc); end
    n_vec++; if (wr_count !== 4) begin n_miss++; $display("FAIL busy_strobes got %0d want 4", wr_count); end
    n_vec++; if (wr_while_busy !== 0) begin n_miss++; $display("FAIL busy_overlap got %0d want 0", wr_while_busy); end
  endtask

  task automatic test_timeout_and_reset();
    bit ok;
    model_en = 1'b0;
    clear_log();
    press_button(25);
    wait_end(100, ok);
    @(negedge clk);
    n_vec++; if (err_count !== 1) begin n_miss++; $display("FAIL tmo_err_count got %0d want 1", err_count); end
    // Tx_WR at s, WAIT_START timer 0..7 over s+1..s+8, tx_err at s+9.
    n_vec++; if (err_cyc - wr_cyc[0] !== 9) begin n_miss++; $display("FAIL tmo_latency got %0d want 9", err_cyc - wr_cyc[0]); end
    n_vec++; if (sending !== 1'b0) begin n_miss++; $display("FAIL tmo_sending got %b want 0", sending); end
    n_vec++; if (done_count !== 0) begin n_miss++; $display("FAIL tmo_done got %0d want 0", done_count); end
    n_vec++; if (tx_err !== 1'b0) begin n_miss++; $display("FAIL tmo_err_pulse_width got %b want 0", tx_err); end
    n_vec++; if (Tx_DATA !== 8'h14) begin n_miss++; $display("FAIL tmo_data_hold got %h want 14", Tx_DATA); end
    repeat (40) @(negedge clk);
    n_vec++; if (wr_count !== 1) begin n_miss++; $display("FAIL tmo_strobes got %0d want 1", wr_count); end

    model_en = 1'b1;
    clear_log();
    press_button(25);
    n_vec++; if (sending !== 1'b1 || wr_count !== 1) begin n_miss++; $display("FAIL rst_mid_state got sending=%b wr=%0d want 1/1", sending, wr_count); end
    reset = 1'b1;
    #1;
    n_vec++; if (Tx_DATA !== 8'h00) begin n_miss++; $display("FAIL rst_mid_data got %h want 00", Tx_DATA); end
    n_vec++; if ({Tx_WR, sending, msg_done, tx_err} !== 4'b0000) begin n_miss++; $display("FAIL rst_mid_flags got %b want 0000", {Tx_WR, sending, msg_done, tx_err}); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    n_vec++; if (wr_count !== 1) begin n_miss++; $display("FAIL rst_mid_strobes got %0d want 1", wr_count); end
    n_vec++; if (done_count + err_count !== 0) begin n_miss++; $display("FAIL rst_mid_events got %0d want 0", done_count + err_count); end
  endtask

  initial begin
    reset  = 1'b1;
    button = 1'b0;
    test_reset();
    test_message();
    test_bounce();
    test_second_press();
    test_busy_at_trigger();
    test_timeout_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
